perf_bus_arbiter: RTL
=====================

# perf_bus_arbiter

Two-master arbiter that shares the FIFO controller's CPU-side peripheral port (address, write data, write enable, read data) between the 64-bit datapath and a second master, such as a host register bridge or a DMA sequencer. Each master presents a valid/ready-style request. The arbiter grants one access per cycle, registers the selected access onto the shared port, and returns read data with a valid strobe. Selection is round-robin, with an optional lock for atomic bursts and a bounded-wait preemption rule.

## Interface
- ADDR_WIDTH, 64, address width of masters and shared port
- DATA_WIDTH, 64, read/write data width
- MAX_HOLD, 8, max consecutive denied cycles a waiting master tolerates under a lock (≥1)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- m0_req / m1_req  in  1  access request, held until granted
- m0_addr / m1_addr  in  ADDR_WIDTH  access address
- m0_wdata / m1_wdata  in  DATA_WIDTH  write data
- m0_wen / m1_wen  in  1  1 = write, 0 = read
- m0_lock / m1_lock  in  1  keep ownership after this access
- m0_gnt / m1_gnt  out  1  combinational accept, same cycle as req
- m0_rdata / m1_rdata  out  DATA_WIDTH  read return data
- m0_rvalid / m1_rvalid  out  1  one-cycle read return strobe
- s_addr  out  ADDR_WIDTH  shared port address (registered)
- s_wdata  out  DATA_WIDTH  shared port write data (registered)
- s_wen  out  1  shared port write enable (registered, one-cycle pulse)
- s_rdata  in  DATA_WIDTH  shared port read data, valid in the same cycle as s_addr

## Operation
- Handshake: a transfer occurs in the cycle where mX_req and mX_gnt are both high. The master may change its request fields at the next edge. At most one gnt is high per cycle. gnt is never high without req.
- States: IDLE, LOCK0, LOCK1. Registered state also includes last_gnt (1 bit) and hold_cnt (width $clog2(MAX_HOLD+1)).
- IDLE arbitration:
  - One requester: that master is granted.
  - Both request: the master ≠ last_gnt is granted.
- LOCKx: only mx is granted. The other master is granted only when it requests and hold_cnt == MAX_HOLD (preemption).
- hold_cnt:
  - In LOCKx, increments each cycle the other master requests and is denied.
  - Clears on any grant to the other master, on lock exit, and in IDLE.
- State update on a granted transfer by mY:
  - If mY_lock = 1, next state is LOCKY.
  - Otherwise, next state is IDLE.
  - last_gnt is set to Y.
  - A preempted owner therefore loses its lock.
- Owner with req low in LOCKx: the state is held, and the waiting master is bounded by MAX_HOLD.
- Shared port, on a granted transfer:
  - s_addr, s_wdata and the mY fields are registered at the edge.
  - s_wen = mY_wen for exactly one cycle.
  - With no grant: s_wen = 0, and s_addr/s_wdata hold their last values.
- Read return: for a granted read, s_rdata is captured at the end of the access cycle into mY_rdata, and mY_rvalid pulses for one cycle. mY_rdata holds its value until the next read return to mY. Writes produce no rvalid.

## Timing
- Reset (rst low, async):
  - s_addr = 0, s_wdata = 0, s_wen = 0.
  - m0/m1_rdata = 0, m0/m1_rvalid = 0.
  - state = IDLE, last_gnt = 1 (m0 wins the first tie), hold_cnt = 0.
  - Deassertion is taken synchronously at the next edge.
- Latency, with request accepted in cycle N:
  - Shared-port access occurs in cycle N+1.
  - rvalid and rdata appear in cycle N+2.
- Throughput: one access per cycle. Back-to-back grants to the same master are allowed when the other master is idle.
- Reset mid-operation: any in-flight access is dropped and no rvalid is issued. The pipeline restarts empty.

## Test plan
- Single read: m0 reads address 0x10 with s_rdata = 0xA5A5 in cycle N+1 -> m0_gnt in N, s_addr = 0x10 with s_wen = 0 in N+1, m0_rvalid = 1 with m0_rdata = 0xA5A5 in N+2.
- Write: m1 writes 0xDEAD to 0x20 -> s_wen = 1, s_addr = 0x20, s_wdata = 0xDEAD for exactly one cycle; no m1_rvalid.
- Round-robin: both masters request continuously from reset -> grants alternate 0,1,0,1…; no double grants.
- Lock with preemption (MAX_HOLD = 4): m0 holds lock=1 while m1 requests -> m0 is granted 4 cycles, m1 is granted on the 5th, state returns to IDLE, m0's lock is dropped.
- Lock release: m0 issues lock=1, lock=1, then lock=0 -> m1 is granted the cycle after m0's final lock=0 transfer.
- Async reset mid-read: rst low during the access cycle -> all outputs are 0 immediately, no rvalid afterwards, and the first tie after reset goes to m0.

Source files
------------

// File: rtl/perf_bus_arbiter_if.sv
// Shared-port arbiter bus: two requesting masters plus the registered peripheral port.
// slave is the arbiter's view; master is the view of the surrounding masters and peripheral.
interface perf_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  m0_req;
    logic                  m1_req;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m0_wen;
    logic                  m1_wen;
    logic                  m0_lock;
    logic                  m1_lock;
    logic                  m0_gnt;
    logic                  m1_gnt;
    logic [DATA_WIDTH-1:0] m0_rdata;
    logic [DATA_WIDTH-1:0] m1_rdata;
    logic                  m0_rvalid;
    logic                  m1_rvalid;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic [DATA_WIDTH-1:0] s_wdata;
    logic                  s_wen;
    logic [DATA_WIDTH-1:0] s_rdata;

    modport slave (
        input  m0_req, m1_req, m0_addr, m1_addr,
        input  m0_wdata, m1_wdata, m0_wen, m1_wen,
        input  m0_lock, m1_lock, s_rdata,
        output m0_gnt, m1_gnt, m0_rdata, m1_rdata,
        output m0_rvalid, m1_rvalid,
        output s_addr, s_wdata, s_wen
    );

    modport master (
        output m0_req, m1_req, m0_addr, m1_addr,
        output m0_wdata, m1_wdata, m0_wen, m1_wen,
        output m0_lock, m1_lock, s_rdata,
        input  m0_gnt, m1_gnt, m0_rdata, m1_rdata,
        input  m0_rvalid, m1_rvalid,
        input  s_addr, s_wdata, s_wen
    );
endinterface

// File: rtl/perf_bus_arbiter.sv
// Two-master round-robin arbiter for the shared peripheral port,
// with ownership lock and bounded-wait preemption of a locked owner.
module perf_bus_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_HOLD   = 8
) (
    input logic               clk,
    input logic               rst,
    perf_bus_arbiter_if.slave bus
);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            g0, g1;
    logic            hold_max;

    logic [ADDR_WIDTH-1:0] s_addr_q;
    logic [DATA_WIDTH-1:0] s_wdata_q;
    logic                  s_wen_q;
    logic                  rd0_q, rd1_q;
    logic                  rv0_q, rv1_q;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

    assign hold_max = (hold_q == HW'(MAX_HOLD));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = '0;
        if (g0) begin
            state_d = bus.m0_lock ? LOCK0 : IDLE;
            last_d  = 1'b0;
        end else if (g1) begin
            state_d = bus.m1_lock ? LOCK1 : IDLE;
            last_d  = 1'b1;
        end
        // Count only denials of the waiting master while the same lock persists
        if (state_q == LOCK0 && state_d == LOCK0 && bus.m1_req && !g1)
            hold_d = hold_max ? hold_q : hold_q + HW'(1);
        if (state_q == LOCK1 && state_d == LOCK1 && bus.m0_req && !g0)
            hold_d = hold_max ? hold_q : hold_q + HW'(1);
    end

    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.m0_req && bus.m1_req) begin
                    g0 = last_q;
                    g1 = !last_q;
                end else begin
                    g0 = bus.m0_req;
                    g1 = bus.m1_req;
                end
            end
            LOCK0: begin
                g1 = bus.m1_req && hold_max;
                g0 = bus.m0_req && !g1;
            end
            LOCK1: begin
                g0 = bus.m0_req && hold_max;
                g1 = bus.m1_req && !g0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_wen_q   <= 1'b0;
            rd0_q     <= 1'b0;
            rd1_q     <= 1'b0;
            rv0_q     <= 1'b0;
            rv1_q     <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            if (g0) begin
                s_addr_q  <= bus.m0_addr;
                s_wdata_q <= bus.m0_wdata;
            end else if (g1) begin
                s_addr_q  <= bus.m1_addr;
                s_wdata_q <= bus.m1_wdata;
            end
            s_wen_q <= (g0 && bus.m0_wen) || (g1 && bus.m1_wen);
            rd0_q   <= g0 && !bus.m0_wen;
            rd1_q   <= g1 && !bus.m1_wen;
            rv0_q   <= rd0_q;
            rv1_q   <= rd1_q;
            if (rd0_q) rdata0_q <= bus.s_rdata;
            if (rd1_q) rdata1_q <= bus.s_rdata;
        end
    end

    assign bus.m0_gnt    = g0;
    assign bus.m1_gnt    = g1;
    assign bus.s_addr    = s_addr_q;
    assign bus.s_wdata   = s_wdata_q;
    assign bus.s_wen     = s_wen_q;
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_rdata  = rdata1_q;
    assign bus.m0_rvalid = rv0_q;
    assign bus.m1_rvalid = rv1_q;
endmodule
